ps2_rx: RTL

- PS/2 device-to-host serial receiver.
- Sits directly upstream of system; drives its key_en/key_data inputs.
- Synchronizes the raw ps2_clk/ps2_dat pins and deserializes 11-bit frames (start, 8 data LSB-first, odd parity, stop).
- Emits one-cycle key_en strobes with the received byte.
- Flags malformed frames and stalled frames.

---
 rtl/ps2_pkg.sv | 27 ++
 rtl/ps2_sync_filter.sv | 71 +++++++
 rtl/ps2_rx.sv | 110 +++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// ============================================================================
// ps2_pkg : shared types and sizing helpers for the PS/2 receiver.  Rev 1.0
// ============================================================================
`default_nettype none

package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  localparam int FRAME_DATA_BITS = 8;
  localparam int TIMEOUT_CYC_DEF = 100000;

  // Width needed to count 0 .. cyc-1, never narrower than one bit.
  function automatic int cnt_width(input int cyc);
    return (cyc > 1) ? $clog2(cyc) : 1;
  endfunction

  localparam int TIMEOUT_CNT_W = cnt_width(TIMEOUT_CYC_DEF);

endpackage

`default_nettype wire

// File: rtl/ps2_sync_filter.sv
// ============================================================================
// ps2_sync_filter : pin synchronizers, optional ps2_clk glitch filter
// (PS2_GLITCH_FILTER_EN) and registered falling-edge pulse.  Rev 1.0
// ============================================================================
`default_nettype none

module ps2_sync_filter
`ifdef PS2_GLITCH_FILTER_EN
#(
  parameter int FILTER_LEN = 8
)
`endif
(
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_dat,
  output logic fall,
  output logic dat
);

  logic clk_s1, clk_s2, dat_s1, dat_s2;
  logic clk_filt, clk_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
      clk_prev <= 1'b1;
      fall     <= 1'b0;
      dat      <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      dat_s1   <= ps2_dat;
      dat_s2   <= dat_s1;
      clk_prev <= clk_filt;
      fall     <= clk_prev & ~clk_filt;
      dat      <= dat_s2;
    end
  end

`ifdef PS2_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);

  logic [FW-1:0] flt_cnt;

  // Filtered level flips only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_filt <= 1'b1;
      flt_cnt  <= '0;
    end else if (clk_s2 == clk_filt) begin
      flt_cnt  <= '0;
    end else if (flt_cnt == FLT_LAST) begin
      clk_filt <= clk_s2;
      flt_cnt  <= '0;
    end else begin
      flt_cnt  <= flt_cnt + 1'b1;
    end
  end
`else
  assign clk_filt = clk_s2;
`endif

endmodule

`default_nettype wire

// File: rtl/ps2_rx.sv
// ============================================================================
// ps2_rx : PS/2 device-to-host frame receiver with parity, framing and
// timeout checks; optional ps2_clk glitch filter via PS2_GLITCH_FILTER_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module ps2_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 100000
`ifdef PS2_GLITCH_FILTER_EN
  ,
  parameter int FILTER_LEN  = 8
`endif
)(
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       key_en,
  output logic [7:0] key_data,
  output logic       err
);

  localparam int CNT_W = cnt_width(TIMEOUT_CYC);
  localparam int BIT_W = $clog2(FRAME_DATA_BITS);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_DATA_BITS - 1);

  logic                       fall, dat;
  state_t                     state;
  logic [BIT_W-1:0]           bit_cnt;
  logic [FRAME_DATA_BITS-1:0] shreg;
  logic                       parity;
  logic [CNT_W-1:0]           to_cnt;

  ps2_sync_filter
`ifdef PS2_GLITCH_FILTER_EN
    #(.FILTER_LEN(FILTER_LEN))
`endif
  u_sync (
    .clk     (clk),
    .reset   (reset),
    .ps2_clk (ps2_clk),
    .ps2_dat (ps2_dat),
    .fall    (fall),
    .dat     (dat)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      parity   <= 1'b0;
      to_cnt   <= '0;
      key_en   <= 1'b0;
      err      <= 1'b0;
      key_data <= 8'h00;
    end else begin
      key_en <= 1'b0;
      err    <= 1'b0;

      if (state == IDLE || fall || to_cnt == TO_LAST)
        to_cnt <= '0;
      else
        to_cnt <= to_cnt + 1'b1;

      // A stalled frame is abandoned; a fresh edge always wins over the stall.
      if (state != IDLE && !fall && to_cnt == TO_LAST) begin
        state <= IDLE;
        err   <= 1'b1;
      end else if (fall) begin
        case (state)
          IDLE: begin
            if (!dat) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              err <= 1'b1;
            end
          end
          DATA: begin
            shreg   <= {dat, shreg[FRAME_DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST)
              state <= PARITY;
          end
          PARITY: begin
            parity <= dat;
            state  <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (dat && (^shreg ^ parity)) begin
              key_data <= shreg;
              key_en   <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire
